sound_latch_ctrl: RTL

- 68k→Z80 sound command path sitting directly downstream of the chip-select decoder.
- Consumes m68k_latch_cs, m68k_sound_cs and z80_latch_cs (plus raw Z80 strobes) and holds the 8-bit sound command.
- Generates the Z80 maskable interrupt and tracks pending/overrun status.
- Supplies read data to both CPUs' data-in muxes.

---
 rtl/sound_latch_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/sound_latch_ctrl.sv
// 68k -> Z80 sound command latch with edge-detected strobes, Z80 interrupt
// generation and pending/overrun status reporting to both CPUs.
module sound_latch_ctrl #(
    parameter int unsigned INT_ON_WRITE = 1,
    parameter int unsigned STATUS_IN_HI = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m68k_latch_cs,
    input  logic [7:0]  m68k_din,
    input  logic        m68k_sound_cs,
    output logic [15:0] m68k_sound_dout,
    input  logic        z80_latch_cs,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic        M1_n,
    input  logic        IORQ_n,
    output logic [7:0]  z80_latch_dout,
    output logic        z80_int_n,
    output logic        pending,
    output logic        overrun
);

    logic [7:0] latch;
    logic       int_n;
    logic       pend_r;
    logic       ovr_r;

    // Cleared by reset; stays low for the first clk after release so a
    // strobe that is already high then only loads its history register.
    logic       armed;

    logic       wr68_q, rd68_q, clrz_q, ackz_q;
    logic       wr68_lvl, rd68_lvl, clrz_lvl, ackz_lvl;
    logic       wr68, rd68, clrz, ackz;

    // Z80 reads are non-destructive, so the read strobe has no effect.
    logic       unused_rd;
    assign unused_rd = RD_n;

    always_comb begin
        wr68_lvl = m68k_latch_cs;
        rd68_lvl = m68k_sound_cs;
        clrz_lvl = z80_latch_cs & ~WR_n;
        ackz_lvl = ~M1_n & ~IORQ_n;

        wr68 = armed & wr68_lvl & ~wr68_q;
        rd68 = armed & rd68_lvl & ~rd68_q;
        clrz = armed & clrz_lvl & ~clrz_q;
        ackz = armed & ackz_lvl & ~ackz_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed  <= 1'b0;
            wr68_q <= 1'b0;
            rd68_q <= 1'b0;
            clrz_q <= 1'b0;
            ackz_q <= 1'b0;
        end else begin
            armed  <= 1'b1;
            wr68_q <= wr68_lvl;
            rd68_q <= rd68_lvl;
            clrz_q <= clrz_lvl;
            ackz_q <= ackz_lvl;
        end
    end

    // Priority order encodes the simultaneous-event rules: a 68k write
    // overrides a Z80 clear/ack, and setting overrun overrides a status read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch  <= '0;
            pend_r <= 1'b0;
            ovr_r  <= 1'b0;
            int_n  <= 1'b1;
        end else begin
            if (wr68) begin
                latch <= m68k_din;
            end

            if (wr68) begin
                pend_r <= 1'b1;
            end else if (clrz) begin
                pend_r <= 1'b0;
            end

            if (wr68 && pend_r) begin
                ovr_r <= 1'b1;
            end else if (rd68) begin
                ovr_r <= 1'b0;
            end

            if (wr68 && (INT_ON_WRITE != 0)) begin
                int_n <= 1'b0;
            end else if (clrz || ackz) begin
                int_n <= 1'b1;
            end
        end
    end

    always_comb begin
        m68k_sound_dout = '0;
        if (STATUS_IN_HI != 0) begin
            m68k_sound_dout[9:8] = {ovr_r, pend_r};
        end else begin
            m68k_sound_dout[1:0] = {ovr_r, pend_r};
        end
    end

    assign z80_latch_dout = latch;
    assign z80_int_n      = int_n;
    assign pending        = pend_r;
    assign overrun        = ovr_r;

endmodule
